// File: rtl/pcb_test_sequencer.sv
// Board-test sequencer: steps relays K_1/K_2 through four settings, requests one ADC
// sample per step and window-checks it. Define RETRY_EN to allow one retry per step on a window miss.
module pcb_test_sequencer #(
   parameter logic [15:0] SETTLE_CYC  = 16'd1000,
   parameter logic [15:0] TIMEOUT_CYC = 16'd5000,
   parameter logic [15:0] LIMIT_LO    = 16'h2000,
   parameter logic [15:0] LIMIT_HI    = 16'h6000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  fault,
   input  logic        tem,
   output logic        adc_req,
   input  logic        adc_ack,
   input  logic [15:0] adc_data,
   output logic        K_1,
   output logic        K_2,
   output logic [1:0]  step,
   output logic [15:0] sample,
   output logic        busy,
   output logic        done,
   output logic        LED1,
   output logic        LED2,
   output logic        LED3,
   output logic        LED4,
   output logic        LED5
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned STEP_W = 2;

   // A zero setting still holds the load for one cycle.
   localparam logic [CNT_W-1:0] SETTLE_LAST  =
      (SETTLE_CYC > 16'd1) ? CNT_W'(SETTLE_CYC - 16'd1) : CNT_W'(0);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST =
      (TIMEOUT_CYC > 16'd1) ? CNT_W'(TIMEOUT_CYC - 16'd1) : CNT_W'(0);
   localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(3);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_CONVERT = 3'd2,
      S_CHECK   = 3'd3,
      S_PASS    = 3'd4,
      S_FAIL    = 3'd5
   } state_e;

   state_e              state_q,     state_d;
   logic [STEP_W-1:0]   step_q,      step_d;
   logic [15:0]         sample_q,    sample_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic                adc_req_q,   adc_req_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                k1_q,        k1_d;
   logic                k2_q,        k2_d;
   logic                pass_led_q,  pass_led_d;
   logic                win_led_q,   win_led_d;
   logic                fault_led_q, fault_led_d;
   logic                tem_led_q,   tem_led_d;
`ifdef RETRY_EN
   logic                retry_q,     retry_d;
`endif

   logic abort_c;
   logic in_window_c;

   assign abort_c     = busy_q && ((|fault) || tem);
   assign in_window_c = (sample_q >= LIMIT_LO) && (sample_q <= LIMIT_HI);

   // Next-state and next-output logic; abort overrides whatever the step logic decided.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      sample_d    = sample_q;
      cnt_d       = cnt_q;
      adc_req_d   = adc_req_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_led_d  = pass_led_q;
      win_led_d   = win_led_q;
      fault_led_d = fault_led_q;
      tem_led_d   = tem_led_q;
`ifdef RETRY_EN
      retry_d     = retry_q;
`endif

      case (state_q)
         S_IDLE, S_PASS, S_FAIL: begin
            if (start) begin
               state_d     = S_SETTLE;
               step_d      = '0;
               cnt_d       = '0;
               busy_d      = 1'b1;
               pass_led_d  = 1'b0;
               win_led_d   = 1'b0;
               fault_led_d = 1'b0;
               tem_led_d   = 1'b0;
`ifdef RETRY_EN
               retry_d     = 1'b0;
`endif
            end
         end
         S_SETTLE: begin
            if (cnt_q >= SETTLE_LAST) begin
               state_d   = S_CONVERT;
               cnt_d     = '0;
               adc_req_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CONVERT: begin
            if (adc_ack) begin
               state_d   = S_CHECK;
               sample_d  = adc_data;
               adc_req_d = 1'b0;
               cnt_d     = '0;
            end else if (cnt_q >= TIMEOUT_LAST) begin
               state_d   = S_FAIL;
               win_led_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CHECK: begin
            cnt_d = '0;
            if (in_window_c) begin
               if (step_q == LAST_STEP) begin
                  state_d = S_PASS;
               end else begin
                  state_d = S_SETTLE;
                  step_d  = step_q + STEP_W'(1);
`ifdef RETRY_EN
                  retry_d = 1'b0;
`endif
               end
            end else begin
`ifdef RETRY_EN
               if (!retry_q) begin
                  state_d = S_SETTLE;
                  retry_d = 1'b1;
               end else begin
                  state_d   = S_FAIL;
                  win_led_d = 1'b1;
               end
`else
               state_d   = S_FAIL;
               win_led_d = 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_c) begin
         state_d     = S_FAIL;
         step_d      = step_q;
         sample_d    = sample_q;
         win_led_d   = win_led_q;
         fault_led_d = fault_led_q | (|fault);
         tem_led_d   = tem_led_q | tem;
      end

      // Any end of a run: release the ADC and relays, pulse done once.
      if (busy_q && ((state_d == S_PASS) || (state_d == S_FAIL))) begin
         busy_d     = 1'b0;
         adc_req_d  = 1'b0;
         cnt_d      = '0;
         done_d     = 1'b1;
         pass_led_d = (state_d == S_PASS);
      end

      k1_d = busy_d & step_d[0];
      k2_d = busy_d & step_d[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         sample_q    <= '0;
         cnt_q       <= '0;
         adc_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         k1_q        <= 1'b0;
         k2_q        <= 1'b0;
         pass_led_q  <= 1'b0;
         win_led_q   <= 1'b0;
         fault_led_q <= 1'b0;
         tem_led_q   <= 1'b0;
`ifdef RETRY_EN
         retry_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         sample_q    <= sample_d;
         cnt_q       <= cnt_d;
         adc_req_q   <= adc_req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         k1_q        <= k1_d;
         k2_q        <= k2_d;
         pass_led_q  <= pass_led_d;
         win_led_q   <= win_led_d;
         fault_led_q <= fault_led_d;
         tem_led_q   <= tem_led_d;
`ifdef RETRY_EN
         retry_q     <= retry_d;
`endif
      end
   end

   assign adc_req = adc_req_q;
   assign K_1     = k1_q;
   assign K_2     = k2_q;
   assign step    = step_q;
   assign sample  = sample_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign LED1    = busy_q;
   assign LED2    = pass_led_q;
   assign LED3    = win_led_q;
   assign LED4    = fault_led_q;
   assign LED5    = tem_led_q;

endmodule
